// File: rtl/l2_arb_pkg.sv
// Shared definitions for the L2 request arbiter: FSM state and
// operation encodings plus the block-width helper.
package l2_arb_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        BUSY = 2'b01,
        DONE = 2'b10
    } state_t;

    typedef enum logic {
        OP_READ  = 1'b0,
        OP_WRITE = 1'b1
    } op_t;

    // Width of one flattened cache block in bits.
    function automatic int calc_bw(input int data_width, input int block_size);
        return data_width * block_size;
    endfunction

endpackage

// File: rtl/rr_arb2.sv
// Two-requester round-robin picker. With both requesters asking, the one
// that did not win last time is chosen; otherwise the lone requester wins.
module rr_arb2 (
    input  logic [1:0] req,
    input  logic       last_grant,
    output logic       gnt_valid,
    output logic       gnt_id
);

    // Pick the winner purely from the current requests and the previous winner.
    always_comb begin
        gnt_valid = |req;
        if (req == 2'b11) begin
            gnt_id = ~last_grant;
        end else begin
            gnt_id = req[1];
        end
    end

endmodule

// File: rtl/l2_req_arbiter.sv
// Shares the single L2 request port between the instruction L1 (port 0)
// and the data L1 (port 1). The winner's request is latched and held on
// the L2 side until L2 answers or the watchdog gives up, and the response
// is returned to the granted port for exactly one cycle.
module l2_req_arbiter
    import l2_arb_pkg::*;
#(
    parameter int DATA_WIDTH     = 32,
    parameter int ADDR_WIDTH     = 11,
    parameter int BLOCK_SIZE     = 32,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic                                          clk,
    input  logic                                          rst_n,
    input  logic [ADDR_WIDTH-1:0]                         req0_addr,
    input  logic                                          req0_read,
    input  logic                                          req0_write,
    input  logic [calc_bw(DATA_WIDTH, BLOCK_SIZE)-1:0]    req0_wdata_flat,
    output logic                                          req0_ready,
    output logic                                          req0_hit,
    output logic                                          req0_valid,
    output logic [calc_bw(DATA_WIDTH, BLOCK_SIZE)-1:0]    req0_rdata_flat,
    input  logic [ADDR_WIDTH-1:0]                         req1_addr,
    input  logic                                          req1_read,
    input  logic                                          req1_write,
    input  logic [calc_bw(DATA_WIDTH, BLOCK_SIZE)-1:0]    req1_wdata_flat,
    output logic                                          req1_ready,
    output logic                                          req1_hit,
    output logic                                          req1_valid,
    output logic [calc_bw(DATA_WIDTH, BLOCK_SIZE)-1:0]    req1_rdata_flat,
    output logic [ADDR_WIDTH-1:0]                         l2_addr,
    output logic                                          l2_read,
    output logic                                          l2_write,
    output logic [calc_bw(DATA_WIDTH, BLOCK_SIZE)-1:0]    l2_wdata_flat,
    input  logic                                          l2_ready,
    input  logic                                          l2_hit,
    input  logic                                          l2_block_valid,
    input  logic [calc_bw(DATA_WIDTH, BLOCK_SIZE)-1:0]    l2_rdata_flat,
    output logic                                          busy,
    output logic                                          grant_id,
    output logic                                          timeout_err
);

    localparam int BW = calc_bw(DATA_WIDTH, BLOCK_SIZE);
    // Counter holds 0..TIMEOUT_CYCLES; a disabled watchdog still needs one bit.
    localparam int CW = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
    localparam logic [CW-1:0] WD_LAST = CW'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);
    localparam bit WD_EN = (TIMEOUT_CYCLES != 0);

    state_t          r_state;
    state_t          w_next_state;
    logic            r_last_grant;
    logic [1:0]      r_served_mask;
    logic [CW-1:0]   r_wd_cnt;
    op_t             r_op;
    logic [ADDR_WIDTH-1:0] r_l2_addr;
    logic [BW-1:0]   r_l2_wdata;
    logic            r_grant_id;
    logic            r_rsp_hit;
    logic            r_rsp_valid;
    logic [BW-1:0]   r_rsp_rdata;
    logic            r_timeout_err;

    logic [1:0]      w_active;
    logic [1:0]      w_eligible;
    logic            w_gnt_valid;
    logic            w_gnt_id;
    logic [ADDR_WIDTH-1:0] w_sel_addr;
    logic [BW-1:0]   w_sel_wdata;
    logic            w_sel_write;
    op_t             w_sel_op;
    logic            w_wd_expire;
    logic            w_in_busy;
    logic            w_in_done;

    // A port is active on either request level; the port just served sits
    // out one IDLE cycle so its not-yet-dropped request is not re-granted.
    assign w_active   = {req1_read | req1_write, req0_read | req0_write};
    assign w_eligible = w_active & ~r_served_mask;

    rr_arb2 u_rr_arb2 (
        .req        (w_eligible),
        .last_grant (r_last_grant),
        .gnt_valid  (w_gnt_valid),
        .gnt_id     (w_gnt_id)
    );

    // Read and write together resolve to a write.
    assign w_sel_addr  = w_gnt_id ? req1_addr       : req0_addr;
    assign w_sel_wdata = w_gnt_id ? req1_wdata_flat : req0_wdata_flat;
    assign w_sel_write = w_gnt_id ? req1_write      : req0_write;
    assign w_sel_op    = w_sel_write ? OP_WRITE : OP_READ;

    assign w_wd_expire = WD_EN && (r_wd_cnt == WD_LAST);

    // State register.
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state logic: grant from IDLE, leave BUSY on L2 ready or watchdog.
    // NOTE: the default assignment first keeps this block free of latches.
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            IDLE:    if (w_gnt_valid) w_next_state = BUSY;
            BUSY:    if (l2_ready || w_wd_expire) w_next_state = DONE;
            DONE:    w_next_state = IDLE;
            default: w_next_state = IDLE;
        endcase
    end

    // Request latch, response capture, watchdog and round-robin history.
    // NOTE: the wide block registers are reset too, because every output,
    // including l2_wdata_flat, must read 0 out of reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_last_grant  <= 1'b1;
            r_served_mask <= 2'b00;
            r_wd_cnt      <= '0;
            r_op          <= OP_READ;
            r_l2_addr     <= '0;
            r_l2_wdata    <= '0;
            r_grant_id    <= 1'b0;
            r_rsp_hit     <= 1'b0;
            r_rsp_valid   <= 1'b0;
            r_rsp_rdata   <= '0;
            r_timeout_err <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    r_served_mask <= 2'b00;
                    if (w_gnt_valid) begin
                        r_l2_addr  <= w_sel_addr;
                        r_l2_wdata <= w_sel_wdata;
                        r_op       <= w_sel_op;
                        r_grant_id <= w_gnt_id;
                        r_wd_cnt   <= '0;
                    end
                end
                BUSY: begin
                    if (l2_ready) begin
                        r_rsp_hit   <= l2_hit;
                        r_rsp_valid <= l2_block_valid;
                        r_rsp_rdata <= l2_rdata_flat;
                    end else begin
                        r_wd_cnt <= r_wd_cnt + CW'(1);
                        if (w_wd_expire) begin
                            r_timeout_err <= 1'b1;
                            r_rsp_hit     <= 1'b0;
                            r_rsp_valid   <= 1'b0;
                            r_rsp_rdata   <= '0;
                        end
                    end
                end
                DONE: begin
                    r_last_grant  <= r_grant_id;
                    r_served_mask <= r_grant_id ? 2'b10 : 2'b01;
                end
                default: ;
            endcase
        end
    end

    assign w_in_busy = (r_state == BUSY);
    assign w_in_done = (r_state == DONE);

    // The L2 request drops combinationally in the L2 ready cycle so the L2
    // never sees a second launch of the same request.
    assign l2_read       = w_in_busy & (r_op == OP_READ)  & ~l2_ready;
    assign l2_write      = w_in_busy & (r_op == OP_WRITE) & ~l2_ready;
    assign l2_addr       = r_l2_addr;
    assign l2_wdata_flat = r_l2_wdata;

    assign busy        = w_in_busy | w_in_done;
    assign grant_id    = r_grant_id;
    assign timeout_err = r_timeout_err;

    // Responses are visible only on the granted port during DONE.
    assign req0_ready      = w_in_done & ~r_grant_id;
    assign req0_hit        = req0_ready & r_rsp_hit;
    assign req0_valid      = req0_ready & r_rsp_valid;
    assign req0_rdata_flat = req0_ready ? r_rsp_rdata : '0;

    assign req1_ready      = w_in_done & r_grant_id;
    assign req1_hit        = req1_ready & r_rsp_hit;
    assign req1_valid      = req1_ready & r_rsp_valid;
    assign req1_rdata_flat = req1_ready ? r_rsp_rdata : '0;

endmodule

// File: tb/tb_l2_req_arbiter.sv
// Bench for l2_req_arbiter: a transaction-level model of the arbiter is
// compared with the DUT on every negative clock edge, and directed tests
// pin the model with hand-computed grant orders, latencies and data.
module tb_l2_req_arbiter;

    localparam int DW  = 32;
    localparam int AW  = 11;
    localparam int BS  = 4;
    localparam int TMO = 8;
    localparam int BW  = DW * BS;

    typedef struct {
        logic [AW-1:0] addr;
        bit            rd;
        bit            wr;
        logic [BW-1:0] wdata;
    } req_t;

    typedef struct {
        int            gid;
        bit            rd;
        bit            wr;
        logic [AW-1:0] addr;
        logic [BW-1:0] wdata;
    } obs_t;

    logic clk;
    logic rst_n;

    logic [1:0]    drv_read;
    logic [1:0]    drv_write;
    logic [AW-1:0] drv_addr  [2];
    logic [BW-1:0] drv_wdata [2];

    logic          req0_ready, req0_hit, req0_valid;
    logic [BW-1:0] req0_rdata_flat;
    logic          req1_ready, req1_hit, req1_valid;
    logic [BW-1:0] req1_rdata_flat;
    logic [AW-1:0] l2_addr;
    logic          l2_read, l2_write;
    logic [BW-1:0] l2_wdata_flat;
    logic          l2_ready, l2_hit, l2_block_valid;
    logic [BW-1:0] l2_rdata_flat;
    logic          busy, grant_id, timeout_err;

    l2_req_arbiter #(
        .DATA_WIDTH     (DW),
        .ADDR_WIDTH     (AW),
        .BLOCK_SIZE     (BS),
        .TIMEOUT_CYCLES (TMO)
    ) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .req0_addr       (drv_addr[0]),
        .req0_read       (drv_read[0]),
        .req0_write      (drv_write[0]),
        .req0_wdata_flat (drv_wdata[0]),
        .req0_ready      (req0_ready),
        .req0_hit        (req0_hit),
        .req0_valid      (req0_valid),
        .req0_rdata_flat (req0_rdata_flat),
        .req1_addr       (drv_addr[1]),
        .req1_read       (drv_read[1]),
        .req1_write      (drv_write[1]),
        .req1_wdata_flat (drv_wdata[1]),
        .req1_ready      (req1_ready),
        .req1_hit        (req1_hit),
        .req1_valid      (req1_valid),
        .req1_rdata_flat (req1_rdata_flat),
        .l2_addr         (l2_addr),
        .l2_read         (l2_read),
        .l2_write        (l2_write),
        .l2_wdata_flat   (l2_wdata_flat),
        .l2_ready        (l2_ready),
        .l2_hit          (l2_hit),
        .l2_block_valid  (l2_block_valid),
        .l2_rdata_flat   (l2_rdata_flat),
        .busy            (busy),
        .grant_id        (grant_id),
        .timeout_err     (timeout_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_total = 0;
    int n_bad   = 0;
    int cyc     = 0;

    // Requester queues and activity flags.
    req_t pq0[$];
    req_t pq1[$];
    bit   port_act[2];

    // L2 responder controls.
    bit            rsp_en;
    int            rsp_lat;
    bit            rsp_hit;
    bit            rsp_valid;
    logic [BW-1:0] rsp_data;

    // Observed grants from the DUT, and the model's own grant history.
    obs_t act_log[$];
    int   m_grants[$];

    // Model state: a transaction is either in flight at L2 or being reported.
    bit            m_inflight, m_report, m_wr, m_terr, m_hit, m_valid;
    int            m_port, m_last, m_served, m_age, m_gid;
    logic [AW-1:0] m_addr;
    logic [BW-1:0] m_wdata, m_rdata;

    task automatic check(input string name, input logic [BW-1:0] act, input logic [BW-1:0] exp);
        n_total++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s cycle=%0d got=%h expected=%h", name, cyc, act, exp);
        end
    endtask

    task automatic fail_now(input string name);
        n_total++;
        n_bad++;
        $display("FAIL %s cycle=%0d wait bound expired", name, cyc);
    endtask

    task automatic model_reset();
        m_inflight = 0; m_report = 0; m_wr = 0; m_terr = 0;
        m_hit = 0; m_valid = 0; m_port = 0; m_last = 1; m_served = -1;
        m_age = 0; m_gid = 0; m_addr = '0; m_wdata = '0; m_rdata = '0;
    endtask

    task automatic model_step();
        bit e0, e1;
        int pick;
        if (m_report) begin
            m_last   = m_port;
            m_served = m_port;
            m_report = 0;
        end else if (m_inflight) begin
            if (l2_ready) begin
                m_hit = l2_hit; m_valid = l2_block_valid; m_rdata = l2_rdata_flat;
                m_inflight = 0; m_report = 1;
            end else if (m_age + 1 == TMO) begin
                m_terr = 1; m_hit = 0; m_valid = 0; m_rdata = '0;
                m_inflight = 0; m_report = 1;
            end else begin
                m_age++;
            end
        end else begin
            e0 = (drv_read[0] || drv_write[0]) && (m_served != 0);
            e1 = (drv_read[1] || drv_write[1]) && (m_served != 1);
            m_served = -1;
            if (e0 && e1)  pick = 1 - m_last;
            else if (e0)   pick = 0;
            else if (e1)   pick = 1;
            else           pick = -1;
            if (pick >= 0) begin
                m_port = pick; m_gid = pick;
                m_wr = drv_write[pick];
                m_addr = drv_addr[pick]; m_wdata = drv_wdata[pick];
                m_age = 0; m_inflight = 1;
                m_grants.push_back(pick);
            end
        end
    endtask

    // Holds a request until ready, keeps it one more cycle, then drops it;
    // a reset abandons the request.
    task automatic run_port(input int p);
        req_t r;
        bit   got, aborted;
        forever begin
            @(posedge clk); #2;
            if (rst_n && ((p == 0) ? pq0.size() : pq1.size()) != 0) begin
                r = (p == 0) ? pq0.pop_front() : pq1.pop_front();
                port_act[p] = 1;
                drv_read[p] = r.rd; drv_write[p] = r.wr;
                drv_addr[p] = r.addr; drv_wdata[p] = r.wdata;
                got = 0; aborted = 0;
                for (int i = 0; i < 200; i++) begin
                    @(negedge clk);
                    if (!rst_n) begin aborted = 1; break; end
                    if ((p == 0) ? req0_ready : req1_ready) begin got = 1; break; end
                end
                if (!got && !aborted) fail_now($sformatf("port%0d_ready_wait", p));
                if (got) begin
                    @(posedge clk); #2;
                    @(posedge clk); #2;
                end
                drv_read[p] = 0; drv_write[p] = 0;
                port_act[p] = 0;
            end
        end
    endtask

    task automatic compare_outputs();
        bit exp_r0, exp_r1;
        exp_r0 = m_report && (m_port == 0);
        exp_r1 = m_report && (m_port == 1);
        check("busy",        busy,        m_inflight || m_report);
        check("l2_read",     l2_read,     m_inflight && !m_wr && !l2_ready);
        check("l2_write",    l2_write,    m_inflight && m_wr && !l2_ready);
        check("l2_addr",     l2_addr,     m_addr);
        check("l2_wdata",    l2_wdata_flat, m_wdata);
        check("grant_id",    grant_id,    m_gid);
        check("timeout_err", timeout_err, m_terr);
        check("req0_ready",  req0_ready,  exp_r0);
        check("req0_hit",    req0_hit,    exp_r0 && m_hit);
        check("req0_valid",  req0_valid,  exp_r0 && m_valid);
        check("req0_rdata",  req0_rdata_flat, exp_r0 ? m_rdata : '0);
        check("req1_ready",  req1_ready,  exp_r1);
        check("req1_hit",    req1_hit,    exp_r1 && m_hit);
        check("req1_valid",  req1_valid,  exp_r1 && m_valid);
        check("req1_rdata",  req1_rdata_flat, exp_r1 ? m_rdata : '0);
    endtask

    task automatic wait_idle();
        bit ok = 0;
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            if (pq0.size() == 0 && pq1.size() == 0 && !port_act[0] && !port_act[1]
                && !m_inflight && !m_report) begin
                ok = 1; break;
            end
        end
        if (!ok) fail_now("idle_wait");
        repeat (2) @(negedge clk);
    endtask

    task automatic wait_l2_read(output int at);
        bit ok = 0;
        at = 0;
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            if (l2_read) begin ok = 1; at = cyc; break; end
        end
        if (!ok) fail_now("l2_read_wait");
    endtask

    task automatic wait_ready(input int p, output int at);
        bit ok = 0;
        at = 0;
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            if ((p == 0) ? req0_ready : req1_ready) begin ok = 1; at = cyc; break; end
        end
        if (!ok) fail_now($sformatf("req%0d_ready_wait", p));
    endtask

    task automatic do_reset();
        @(posedge clk); #2;
        rst_n = 0;
        repeat (2) @(negedge clk);
        rst_n = 1;
    endtask

    function automatic req_t mk(input logic [AW-1:0] a, input bit rd, input bit wr,
                                input logic [BW-1:0] wd);
        req_t r;
        r.addr = a; r.rd = rd; r.wr = wr; r.wdata = wd;
        return r;
    endfunction

    initial begin
        int   t_a, t_r, n_rd;
        bit   prev_busy;
        obs_t o;
        logic [BW-1:0] w1, w2;

        rst_n = 0;
        drv_read = '0; drv_write = '0;
        drv_addr[0] = '0; drv_addr[1] = '0;
        drv_wdata[0] = '0; drv_wdata[1] = '0;
        l2_ready = 0; l2_hit = 0; l2_block_valid = 0; l2_rdata_flat = '0;
        rsp_en = 0; rsp_lat = 3; rsp_hit = 1; rsp_valid = 1; rsp_data = '0;
        port_act[0] = 0; port_act[1] = 0;
        prev_busy = 0;
        model_reset();
        w1 = 128'h11112222_33334444_55556666_77778888;
        w2 = 128'hA5A5A5A5_0F0F0F0F_C3C3C3C3_99999999;

        fork
            forever begin
                @(posedge clk or negedge rst_n);
                if (!rst_n) model_reset();
                else begin
                    cyc++;
                    model_step();
                end
            end
            forever begin
                @(negedge clk);
                compare_outputs();
                if (busy && !prev_busy) begin
                    o.gid = grant_id; o.rd = l2_read; o.wr = l2_write;
                    o.addr = l2_addr; o.wdata = l2_wdata_flat;
                    act_log.push_back(o);
                end
                prev_busy = busy;
            end
            run_port(0);
            run_port(1);
            forever begin
                @(negedge clk);
                if (rsp_en && (l2_read || l2_write)) begin
                    repeat (rsp_lat) @(posedge clk);
                    #2;
                    l2_ready = 1; l2_hit = rsp_hit; l2_block_valid = rsp_valid;
                    l2_rdata_flat = rsp_data;
                    @(posedge clk); #2;
                    l2_ready = 0; l2_hit = 0; l2_block_valid = 0; l2_rdata_flat = '0;
                end
            end
        join_none

        // Reset state.
        @(negedge clk);
        check("rst_busy", busy, 0);
        check("rst_grant_id", grant_id, 0);
        check("rst_l2_read", l2_read, 0);
        check("rst_timeout_err", timeout_err, 0);
        @(negedge clk);
        rst_n = 1;
        repeat (2) @(negedge clk);

        // 1. Single read from port 0, L2 answers 3 cycles after l2_read.
        rsp_en = 1; rsp_lat = 3; rsp_hit = 1; rsp_valid = 1;
        rsp_data = 128'h0000_0000_0000_0000_0000_0000_DEAD_BEEF;
        pq0.push_back(mk(11'h140, 1, 0, '0));
        wait_l2_read(t_a);
        check("t1_l2_addr", l2_addr, 11'h140);
        wait_ready(0, t_r);
        check("t1_latency", t_r - t_a, 4);
        check("t1_hit", req0_hit, 1);
        check("t1_valid", req0_valid, 1);
        check("t1_word0", req0_rdata_flat[31:0], 32'hDEADBEEF);
        check("t1_req1_ready", req1_ready, 0);
        check("t1_req1_rdata", req1_rdata_flat, '0);
        wait_idle();

        // 2. Simultaneous requests straight out of reset.
        do_reset();
        act_log.delete(); m_grants.delete();
        rsp_data = 128'h1;
        pq0.push_back(mk(11'h040, 1, 0, '0));
        pq1.push_back(mk(11'h080, 0, 1, w1));
        wait_idle();
        check("t2_count", act_log.size(), 2);
        if (act_log.size() == 2) begin
            check("t2_gid0", act_log[0].gid, 0);
            check("t2_gid1", act_log[1].gid, 1);
            check("t2_wr1", act_log[1].wr, 1);
            check("t2_addr1", act_log[1].addr, 11'h080);
            check("t2_wdata1", act_log[1].wdata, w1);
        end

        // 3. Continuous contention, three transactions per port.
        act_log.delete(); m_grants.delete();
        for (int i = 0; i < 3; i++) begin
            pq0.push_back(mk(11'h200 + 11'(4 * i), 1, 0, '0));
            pq1.push_back(mk(11'h300 + 11'(4 * i), 1, 0, '0));
        end
        wait_idle();
        check("t3_count", act_log.size(), 6);
        check("t3_model_count", m_grants.size(), 6);
        if (act_log.size() == 6 && m_grants.size() == 6) begin
            for (int i = 0; i < 6; i++) begin
                check($sformatf("t3_gid%0d", i), act_log[i].gid, i % 2);
                check($sformatf("t3_model_gid%0d", i), m_grants[i], i % 2);
                check($sformatf("t3_addr%0d", i), act_log[i].addr,
                      (i % 2 == 0) ? 11'h200 + 11'(4 * (i / 2)) : 11'h300 + 11'(4 * (i / 2)));
            end
        end

        // 4. Read and write both high on port 1 resolves to a write.
        act_log.delete();
        pq1.push_back(mk(11'h1E0, 1, 1, w2));
        wait_idle();
        check("t4_count", act_log.size(), 1);
        if (act_log.size() == 1) begin
            check("t4_write", act_log[0].wr, 1);
            check("t4_read", act_log[0].rd, 0);
            check("t4_addr", act_log[0].addr, 11'h1E0);
            check("t4_gid", act_log[0].gid, 1);
        end

        // 5. Watchdog: L2 never answers.
        rsp_en = 0;
        pq0.push_back(mk(11'h020, 1, 0, '0));
        n_rd = 0;
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            if (req0_ready) break;
            if (l2_read) n_rd++;
        end
        check("t5_read_cycles", n_rd, TMO);
        check("t5_ready", req0_ready, 1);
        check("t5_valid", req0_valid, 0);
        check("t5_hit", req0_hit, 0);
        check("t5_rdata", req0_rdata_flat, '0);
        @(negedge clk);
        check("t5_timeout_err", timeout_err, 1);
        wait_idle();
        rsp_en = 1;
        pq0.push_back(mk(11'h060, 1, 0, '0));
        wait_ready(0, t_r);
        check("t5_after_valid", req0_valid, 1);
        check("t5_err_sticky", timeout_err, 1);
        wait_idle();

        // l2_ready outside BUSY is ignored.
        rsp_en = 0;
        @(posedge clk); #2;
        l2_ready = 1; l2_hit = 1; l2_block_valid = 1;
        @(posedge clk); #2;
        l2_ready = 0; l2_hit = 0; l2_block_valid = 0;
        @(negedge clk);
        check("stray_busy", busy, 0);
        check("stray_req0_ready", req0_ready, 0);

        // 6. Reset two cycles into a read, then port 1 alone.
        pq0.push_back(mk(11'h100, 1, 0, '0));
        wait_l2_read(t_a);
        @(posedge clk); #2;
        rst_n = 0;
        #1;
        check("t6_l2_read", l2_read, 0);
        check("t6_busy", busy, 0);
        check("t6_timeout_err", timeout_err, 0);
        repeat (2) @(negedge clk);
        rst_n = 1;
        act_log.delete();
        rsp_en = 1;
        pq1.push_back(mk(11'h0C0, 1, 0, '0));
        wait_ready(1, t_r);
        check("t6_count", act_log.size(), 1);
        if (act_log.size() == 1) check("t6_gid", act_log[0].gid, 1);
        check("t6_err_clear", timeout_err, 0);
        wait_idle();

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule

// File: doc/l2_req_arbiter.md
Name: l2_req_arbiter

Overview:
Shares the single L2 cache request port between two L1 requesters (port 0: instruction L1, port 1: data L1).
- Round-robin grant between the two ports.
- Latches the winner's address, operation and write block, and holds them stable on the L2 side until the L2 ready pulse.
- Routes the L2 response back to the granted port only.
- A watchdog terminates L2 transactions that never complete.

Parameters:
DATA_WIDTH, 32, bits per word
ADDR_WIDTH, 11, byte address width
BLOCK_SIZE, 32, words per cache block; BW = BLOCK_SIZE*DATA_WIDTH
TIMEOUT_CYCLES, 1024, max BUSY cycles before forced completion; 0 disables the watchdog

Ports:
clk  in  1  clock; all logic on rising edge
rst_n  in  1  reset, asynchronous, active-low
reqN_addr  in  ADDR_WIDTH  port N request address (N = 0, 1)
reqN_read  in  1  port N read request, level, held until reqN_ready
reqN_write  in  1  port N write request, level, held until reqN_ready
reqN_wdata_flat  in  BW  port N write block, word g at bits [(g+1)*DATA_WIDTH-1 -: DATA_WIDTH]
reqN_ready  out  1  port N one-cycle completion pulse
reqN_hit  out  1  port N L2 hit flag, valid with reqN_ready
reqN_valid  out  1  port N block-valid flag, valid with reqN_ready
reqN_rdata_flat  out  BW  port N returned block, valid with reqN_ready
l2_addr  out  ADDR_WIDTH  latched address to L2
l2_read  out  1  read request to L2
l2_write  out  1  write request to L2
l2_wdata_flat  out  BW  latched write block to L2
l2_ready  in  1  L2 completion pulse
l2_hit  in  1  L2 hit flag
l2_block_valid  in  1  L2 block-valid flag
l2_rdata_flat  in  BW  L2 returned block
busy  out  1  high in BUSY and DONE
grant_id  out  1  id of the current or last granted port
timeout_err  out  1  sticky watchdog error flag

Behaviour:
- Reset: every output is 0, state = IDLE, last_grant = 1 (so port 0 wins the first tie), served_mask = 0, watchdog counter = 0. Reset is asynchronous and takes effect immediately, including mid-transaction; l2_read and l2_write drop in the same cycle.
- Request decode per port: active = read | write. If read and write are both high, the operation is a write.
- Port protocol: a requester holds its request and data stable until reqN_ready, then deasserts in the following cycle.
- IDLE:
  - eligible = active & ~served_mask. served_mask holds the port served in the preceding DONE and is cleared after one IDLE cycle.
  - With two eligible ports, grant the port != last_grant. With one eligible port, grant it.
  - On grant: latch addr, op and wdata into l2_* registers, set grant_id, clear the watchdog counter, go to BUSY.
- BUSY:
  - l2_read = op_is_read & ~l2_ready and l2_write = op_is_write & ~l2_ready. This is combinational gating, so the request is already low during the L2 ready cycle and the L2 does not relaunch.
  - l2_addr and l2_wdata_flat stay constant.
  - On l2_ready: capture hit, block_valid and rdata into response registers, go to DONE.
  - Otherwise increment the watchdog counter. If TIMEOUT_CYCLES != 0 and the counter reaches TIMEOUT_CYCLES-1: set timeout_err, capture hit=0, valid=0, rdata=0, go to DONE.
- DONE, exactly one cycle:
  - reqG_ready = 1 for the granted port G, with reqG_hit, reqG_valid and reqG_rdata_flat driven from the captured response.
  - The other port's response outputs stay 0.
  - last_grant = G, served_mask = G, go to IDLE.
- Latency: request seen in IDLE at cycle c → l2_read/l2_write high from c+1 → reqG_ready exactly 1 cycle after the l2_ready cycle.
- A new request issues to L2 at the earliest 2 cycles after reqG_ready.
- l2_ready received outside BUSY is ignored.
- reqN_rdata_flat is 0 whenever reqN_ready is 0.
- timeout_err is cleared only by reset.
- Watchdog counter width: $clog2(TIMEOUT_CYCLES+1), minimum 1 bit.

Decomposition:
- Shared package l2_arb_pkg holds:
  - state encoding (IDLE = 2'b00, BUSY = 2'b01, DONE = 2'b10)
  - op encoding (OP_READ = 1'b0, OP_WRITE = 1'b1)
  - the BW width function
- One sub-module, rr_arb2: a two-requester round-robin picker with inputs req[1:0] and last_grant, and outputs gnt_valid and gnt_id. It is purely combinational.
- The FSM, latches and watchdog live in l2_req_arbiter.

Test Plan:
1. Single read: port 0 read addr 0x140, L2 returns ready 3 cycles after l2_read rises with hit=1 and rdata word0=0xDEADBEEF → req0_ready, req0_hit and req0_valid pulse 1 cycle after l2_ready, word0 = 0xDEADBEEF; req1 outputs stay 0.
2. Simultaneous requests from reset: port 0 read 0x040 and port 1 write 0x080 in the same cycle → port 0 is served first, then l2_write with l2_addr=0x080 and l2_wdata equal to port 1's block; grant_id sequence is 0, then 1.
3. Continuous contention: both ports hold requests back-to-back for 6 transactions → grants alternate 0, 1, 0, 1, 0, 1; l2_addr never changes while busy=1.
4. Read+write both high on port 1 (addr 0x1E0) → L2 sees l2_write=1, l2_read=0.
5. Watchdog: TIMEOUT_CYCLES=8, L2 never asserts ready → l2_read is high for 8 cycles, then req0_ready=1, req0_valid=0, req0_hit=0; timeout_err=1 until reset; a subsequent request proceeds normally.
6. Reset mid-BUSY: rst_n pulled low 2 cycles into a read → l2_read, busy and timeout_err go to 0 immediately; after release, a port 1 request is granted first only if port 0 is idle.
